bmem_readback_sender: RTL and testbench

// Transmit side of the host serial link: dumps one block-memory tile group back to the host over the UART.

---
 rtl/bmem_readback_sender.sv | 144 ++++++++++++++
 tb/tb_bmem_readback_sender.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_readback_sender.sv
// Readback path for the host link: snapshots one block-memory tile group and
// streams it to the UART as a BMEM frame (header, address bytes, data bytes).
module bmem_readback_sender #(
  parameter int          BITWIDTH  = 32,
  parameter int          MESHUNITS = 2,
  parameter int          TILEUNITS = 2,
  parameter logic [7:0]  HEADER    = 8'h80
) (
  input  logic                                                          clock,
  input  logic                                                          reset,
  input  logic                                                          dump_req_i,
  input  logic [BITWIDTH-1:0]                                           dump_addr_i,
  output logic                                                          dump_ready_o,
  output logic                                                          dump_done_o,
  output logic [BITWIDTH-1:0]                                           mem_read_addr_o,
  output logic                                                          mem_read_valid_o,
  input  logic [BITWIDTH*MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS-1:0]   mem_read_data_i,
  output logic                                                          write_lock_req_o,
  input  logic                                                          write_lock_res_i,
  input  logic                                                          write_ready_i,
  output logic [7:0]                                                    data_out_o,
  output logic                                                          data_out_valid_o
);

  localparam int NWORDS = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
  localparam int NBYTES = BITWIDTH / 8;
  localparam int TOTAL  = 1 + NBYTES + NBYTES * NWORDS;
  localparam int CW     = $clog2(TOTAL + 1);
  localparam int FW     = TOTAL * 8;
  localparam int IW     = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOCK, SEND, DONE} state_t;

  state_t                       state_q;
  logic [CW-1:0]                k_q;
  logic [BITWIDTH-1:0]          addr_q;
  logic [BITWIDTH*NWORDS-1:0]   snapBuf_q;
  logic                         snap_q;
  logic                         dumpReady_q;
  logic                         dumpDone_q;
  logic                         memReadValid_q;
  logic                         lockReq_q;
  logic                         outValid_q;
  logic [7:0]                   dataOut_q;

  logic [FW-1:0]                frameVec;
  logic [CW-1:0]                kInc;
  logic [IW-1:0]                curIdx;
  logic [IW-1:0]                nextIdx;
  logic [7:0]                   curByte;
  logic [7:0]                   nextByte;

  // The whole frame laid out LSB-first, so byte k is simply bits [8k +: 8].
  assign frameVec = {snapBuf_q, addr_q, HEADER};
  assign kInc     = k_q + CW'(1);
  assign curIdx   = IW'({k_q, 3'b000});
  assign nextIdx  = IW'({kInc, 3'b000});
  assign curByte  = frameVec[curIdx +: 8];
  assign nextByte = frameVec[nextIdx +: 8];

  // Blockmem answers one cycle after the strobe, so the snapshot is taken on
  // the edge after FETCH; nothing reads data bytes before SEND anyway.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      k_q            <= '0;
      addr_q         <= '0;
      snapBuf_q      <= '0;
      snap_q         <= 1'b0;
      dumpReady_q    <= 1'b1;
      dumpDone_q     <= 1'b0;
      memReadValid_q <= 1'b0;
      lockReq_q      <= 1'b0;
      outValid_q     <= 1'b0;
      dataOut_q      <= '0;
    end else begin
      if (snap_q) begin
        snapBuf_q <= mem_read_data_i;
        snap_q    <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (dump_req_i) begin
            addr_q         <= dump_addr_i;
            memReadValid_q <= 1'b1;
            dumpReady_q    <= 1'b0;
            k_q            <= '0;
            state_q        <= FETCH;
          end
        end
        FETCH: begin
          memReadValid_q <= 1'b0;
          snap_q         <= 1'b1;
          lockReq_q      <= 1'b1;
          state_q        <= LOCK;
        end
        LOCK: begin
          if (write_lock_res_i) begin
            dataOut_q  <= curByte;
            outValid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // A byte offered while the grant falls still counts; only then do we back off.
          if (write_ready_i) begin
            if (k_q == LAST) begin
              lockReq_q  <= 1'b0;
              outValid_q <= 1'b0;
              dumpDone_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              k_q       <= kInc;
              dataOut_q <= nextByte;
              if (!write_lock_res_i) begin
                outValid_q <= 1'b0;
                state_q    <= LOCK;
              end
            end
          end else if (!write_lock_res_i) begin
            outValid_q <= 1'b0;
            state_q    <= LOCK;
          end
        end
        DONE: begin
          dumpDone_q  <= 1'b0;
          dumpReady_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dump_ready_o     = dumpReady_q;
  assign dump_done_o      = dumpDone_q;
  assign mem_read_addr_o  = addr_q;
  assign mem_read_valid_o = memReadValid_q;
  assign write_lock_req_o = lockReq_q;
  assign data_out_o       = dataOut_q;
  assign data_out_valid_o = outValid_q;

endmodule

// File: tb/tb_bmem_readback_sender.sv
// Bench for bmem_readback_sender: scenario table plus randomized dumps, each
// frame compared against a byte-list model built from the framing rules.
module tb_bmem_readback_sender;

  localparam int BW    = 32;
  localparam int MESH  = 1;
  localparam int TILE  = 2;
  localparam int NW    = MESH * MESH * TILE * TILE;
  localparam int NB    = BW / 8;
  localparam int TOTAL = 1 + NB + NB * NW;

  typedef logic [7:0] byteq_t [$];
  typedef struct {
    string       name;
    logic [31:0] addr;
    int          grantDelay;
    int          readyMode;
    int          revokeAfter;
    int          pokeAt;
    bit          holdReq;
    int          abortAt;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              dump_req;
  logic [BW-1:0]     dump_addr;
  logic              dump_ready;
  logic              dump_done;
  logic [BW-1:0]     mem_read_addr;
  logic              mem_read_valid;
  logic [BW*NW-1:0]  mem_read_data;
  logic              write_lock_req;
  logic              write_lock_res;
  logic              write_ready;
  logic [7:0]        data_out;
  logic              data_out_valid;

  int                checks = 0;
  int                errors = 0;
  logic [31:0]       bank [16][NW];
  logic [3:0]        rdIdx = '0;
  logic [7:0]        rxQ [$];
  bit                monEn = 1'b0;
  int                lockViol;
  bit                prevHold = 1'b0;
  logic [7:0]        prevByte;
  logic [7:0]        golden [TOTAL];
  vec_t              vecs [8];

  bmem_readback_sender #(.BITWIDTH(BW), .MESHUNITS(MESH), .TILEUNITS(TILE), .HEADER(8'h80)) dut (
    .clock            (clock),
    .reset            (reset),
    .dump_req_i       (dump_req),
    .dump_addr_i      (dump_addr),
    .dump_ready_o     (dump_ready),
    .dump_done_o      (dump_done),
    .mem_read_addr_o  (mem_read_addr),
    .mem_read_valid_o (mem_read_valid),
    .mem_read_data_i  (mem_read_data),
    .write_lock_req_o (write_lock_req),
    .write_lock_res_i (write_lock_res),
    .write_ready_i    (write_ready),
    .data_out_o       (data_out),
    .data_out_valid_o (data_out_valid)
  );

  always #5 clock = ~clock;

  // Block memory: the read port shows the last strobed block one cycle later
  // and keeps following later writes to that block.
  always @(posedge clock) begin
    logic [BW*NW-1:0] tmp;
    if (mem_read_valid) rdIdx = mem_read_addr[3:0];
    for (int w = 0; w < NW; w++) tmp[w*BW +: BW] = bank[rdIdx][w];
    mem_read_data <= tmp;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // UART side: records every accepted byte and checks a held byte stays put.
  always @(negedge clock) begin
    if (monEn && !reset) begin
      if (data_out_valid && write_ready) begin
        rxQ.push_back(data_out);
        if (!write_lock_req) lockViol++;
      end
      if (prevHold && data_out_valid) checkOutput("stable_while_stalled", {24'd0, data_out}, {24'd0, prevByte});
      prevHold = data_out_valid && !write_ready;
      prevByte = data_out;
    end else begin
      prevHold = 1'b0;
    end
  end

  function automatic byteq_t expFrame(input logic [31:0] addr, input logic [31:0] words [NW]);
    byteq_t q;
    q.push_back(8'h80);
    for (int j = 0; j < NB; j++) q.push_back(8'((addr >> (8 * j)) & 32'hFF));
    for (int w = 0; w < NW; w++)
      for (int j = 0; j < NB; j++) q.push_back(8'((words[w] >> (8 * j)) & 32'hFF));
    return q;
  endfunction

  task automatic applyStimulus(input vec_t v);
    logic [31:0] snap [NW];
    byteq_t      exp;
    int          idx, c, grantCnt, revCnt, strobes, readyViol, expCount;
    bit          done, aborted, revoked, poked, reqSeen, doneSeen;
    idx = int'(v.addr[3:0]);
    for (int w = 0; w < NW; w++) snap[w] = bank[idx][w];
    exp = expFrame(v.addr, snap);
    $display("[TB] scenario %s", v.name);
    rxQ.delete();
    lockViol = 0; readyViol = 0; strobes = 0;
    done = 0; aborted = 0; revoked = 0; poked = 0;
    c = 0; grantCnt = 0; revCnt = 0;
    monEn = 1'b1;
    @(posedge clock); #1;
    dump_req  = 1'b1;
    dump_addr = v.addr;
    @(negedge clock); #1;
    checkOutput({v.name, " ready_before_accept"}, {31'd0, dump_ready}, 32'd1);
    @(posedge clock); #1;
    if (!v.holdReq) dump_req = 1'b0;
    while (!done && !aborted && c < 400) begin
      @(negedge clock); #1;
      if (mem_read_valid) begin
        strobes++;
        checkOutput({v.name, " read_addr"}, mem_read_addr, v.addr);
      end
      if (dump_ready) readyViol++;
      if (dump_done) begin
        done = 1;
        checkOutput({v.name, " lock_released_at_done"}, {31'd0, write_lock_req}, 32'd0);
        checkOutput({v.name, " valid_low_at_done"}, {31'd0, data_out_valid}, 32'd0);
      end
      if (v.abortAt > 0 && rxQ.size() >= v.abortAt) aborted = 1;
      if (v.pokeAt > 0 && !poked && rxQ.size() >= v.pokeAt) begin
        poked = 1;
        for (int w = 0; w < NW; w++) bank[idx][w] = ~bank[idx][w];
      end
      reqSeen = write_lock_req;
      @(posedge clock); #1;
      if (done) dump_req = 1'b0;
      if (revCnt > 0) begin
        revCnt--;
        write_lock_res = (revCnt == 0);
      end else if (v.revokeAfter > 0 && !revoked && rxQ.size() >= v.revokeAfter) begin
        revoked = 1; revCnt = 5; write_lock_res = 1'b0;
      end else if (!reqSeen) begin
        write_lock_res = 1'b0; grantCnt = 0;
      end else if (!write_lock_res) begin
        grantCnt++;
        if (grantCnt >= v.grantDelay) write_lock_res = 1'b1;
      end
      case (v.readyMode)
        0:       write_ready = 1'b1;
        1:       write_ready = (c % 4 == 0) || (c % 4 == 3);
        default: write_ready = ($urandom_range(0, 3) != 0);
      endcase
      c++;
    end
    if (!done && !aborted) checkOutput({v.name, " frame_timeout"}, 32'd1, 32'd0);
    expCount = aborted ? v.abortAt : TOTAL;
    checkOutput({v.name, " byte_count"}, rxQ.size(), expCount);
    for (int i = 0; i < expCount && i < rxQ.size(); i++)
      checkOutput($sformatf("%s byte%0d", v.name, i), {24'd0, rxQ[i]}, {24'd0, exp[i]});
    checkOutput({v.name, " one_read_strobe"}, strobes, 32'd1);
    checkOutput({v.name, " lock_held_per_byte"}, lockViol, 32'd0);
    checkOutput({v.name, " ready_low_while_busy"}, readyViol, 32'd0);
    if (done) begin
      @(negedge clock); #1;
      checkOutput({v.name, " done_one_cycle"}, {31'd0, dump_done}, 32'd0);
      checkOutput({v.name, " ready_back_in_idle"}, {31'd0, dump_ready}, 32'd1);
    end
    if (aborted) begin
      reset = 1'b1; write_ready = 1'b0; dump_req = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0; write_lock_res = 1'b0;
      @(negedge clock); #1;
      checkOutput({v.name, " abort_lock_dropped"}, {31'd0, write_lock_req}, 32'd0);
      checkOutput({v.name, " abort_valid_dropped"}, {31'd0, data_out_valid}, 32'd0);
      checkOutput({v.name, " abort_ready"}, {31'd0, dump_ready}, 32'd1);
      doneSeen = dump_done;
      repeat (6) begin
        @(negedge clock); #1;
        if (dump_done) doneSeen = 1;
      end
      checkOutput({v.name, " abort_no_done"}, {31'd0, doneSeen}, 32'd0);
    end
    monEn = 1'b0;
    write_lock_res = 1'b0;
  endtask

  initial begin
    vec_t        rv;
    logic [31:0] tmp;
    int          ridx;
    reset = 1'b1; dump_req = 1'b0; dump_addr = '0;
    write_lock_res = 1'b0; write_ready = 1'b0;
    for (int b = 0; b < 16; b++)
      for (int w = 0; w < NW; w++) bank[b][w] = 32'(b * 16 + w);
    bank[0][0] = 32'h11223344; bank[0][1] = 32'h55667788;
    bank[0][2] = 32'h99AABBCC; bank[0][3] = 32'hDDEEFF00;
    bank[7][0] = 32'hCAFEF00D; bank[7][1] = 32'h01020304;
    bank[7][2] = 32'hA5A55A5A; bank[7][3] = 32'h0000FFFF;
    golden = '{8'h80, 8'h10, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77,
               8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h00, 8'hFF, 8'hEE, 8'hDD};
    vecs[0] = '{"T1_basic",    32'h10,       3, 0, 0,  0, 1'b0, 0};
    vecs[1] = '{"T2_ready",    32'h10,       3, 1, 0,  0, 1'b0, 0};
    vecs[2] = '{"T3_revoke",   32'h10,       2, 0, 7,  0, 1'b0, 0};
    vecs[3] = '{"T4_holdreq",  32'h10,       1, 0, 0,  0, 1'b1, 0};
    vecs[4] = '{"T5_abort",    32'h10,       3, 0, 0,  0, 1'b0, 10};
    vecs[5] = '{"T5_fresh",    32'h10,       0, 0, 0,  0, 1'b0, 0};
    vecs[6] = '{"T6_snapshot", 32'h10,       2, 1, 0,  8, 1'b0, 0};
    vecs[7] = '{"mixed",       32'hABCD0007, 4, 1, 12, 6, 1'b1, 0};

    repeat (3) @(posedge clock);
    #1;
    @(negedge clock); #1;
    checkOutput("reset_dump_ready", {31'd0, dump_ready}, 32'd1);
    checkOutput("reset_dump_done", {31'd0, dump_done}, 32'd0);
    checkOutput("reset_read_valid", {31'd0, mem_read_valid}, 32'd0);
    checkOutput("reset_lock_req", {31'd0, write_lock_req}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, data_out_valid}, 32'd0);
    checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      if (i == 0)
        for (int j = 0; j < TOTAL && j < rxQ.size(); j++)
          checkOutput($sformatf("T1_golden byte%0d", j), {24'd0, rxQ[j]}, {24'd0, golden[j]});
    end

    for (int r = 0; r < 8; r++) begin
      ridx = $urandom_range(0, 15);
      for (int w = 0; w < NW; w++) bank[ridx][w] = $urandom();
      tmp            = $urandom();
      rv.name        = $sformatf("random%0d", r);
      rv.addr        = {tmp[31:4], 4'(ridx)};
      rv.grantDelay  = $urandom_range(0, 6);
      rv.readyMode   = 2;
      rv.revokeAfter = $urandom_range(0, 18);
      rv.pokeAt      = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 20) : 0;
      rv.holdReq     = 1'($urandom_range(0, 1));
      rv.abortAt     = 0;
      applyStimulus(rv);
    end

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
